// File: rtl/ram_chk_pkg.sv
// Shared types, default widths and the expected-pattern helper for the RAM read-back checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ram_chk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chk_state_e;

    localparam int ADDR_W_DEF   = 6;
    localparam int DATA_W_DEF   = 8;
    localparam int RD_LAT_DEF   = 1;
    localparam int DATA_OFS_DEF = 0;
    localparam int ERR_W_DEF    = 16;

    // Word written at each address: address plus offset. The caller truncates the
    // result to DATA_W, which yields the mod 2^DATA_W wrap (negative offsets included).
    function automatic logic [31:0] exp_word(input logic [31:0] addr, input int ofs);
        return addr + 32'(ofs);
    endfunction

endpackage

// File: rtl/ram_rd_chk_if.sv
// RAM port-B tap bundle: read enable, read address and returned read data.
// Latency: none (wires only).
// Backpressure: none; the master side drives every signal, the checker only observes.
interface ram_rd_chk_if
    import ram_chk_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              ram_en_b;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [DATA_W-1:0] ram_rd_data;

    // master: the RAM/controller side that produces the port-B signals
    modport master (output ram_en_b, ram_addr_b, ram_rd_data);
    // slave: the checker, which only taps them
    modport slave  (input  ram_en_b, ram_addr_b, ram_rd_data);
endinterface

// File: rtl/ram_rd_dly.sv
// Delays read enable + address by RD_LAT cycles so they line up with RAM read data.
// Latency: RD_LAT cycles (legal 1..3); synchronous reset clears every stage.
// Backpressure: none; one new entry accepted every cycle.
// Ports: sys_clk/sys_rst, in_vld/in_addr (tap), out_vld/out_addr (aligned sample).
module ram_rd_dly
    import ram_chk_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr
);
    logic [RD_LAT-1:0] vld_q;
    logic [ADDR_W-1:0] addr_q [RD_LAT];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
        end else begin
            vld_q[0]  <= in_vld;
            addr_q[0] <= in_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign out_vld  = vld_q[RD_LAT-1];
    assign out_addr = addr_q[RD_LAT-1];
endmodule

// File: rtl/ram_rd_chk.sv
// Read-back checker on RAM port B: compares returned words to the address+offset pattern.
// Latency: status pulses RD_LAT+1 cycles after the enable; counters update in the same cycle.
// Backpressure: none; one compare per cycle for back-to-back enables, gaps are legal.
// Ports: sys_clk/sys_rst, tap (port-B enable/address/data), chk_vld/chk_err/seq_err/pass_done
//        pulses, pass_ok level, err_cnt (saturating), pass_cnt (wrapping), first-error capture.
module ram_rd_chk
    import ram_chk_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RD_LAT   = RD_LAT_DEF,
    parameter int DATA_OFS = DATA_OFS_DEF,
    parameter int ERR_W    = ERR_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    ram_rd_chk_if.slave       tap,
    output logic              chk_vld,
    output logic              chk_err,
    output logic              seq_err,
    output logic              pass_done,
    output logic              pass_ok,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [15:0]       pass_cnt,
    output logic              first_err_vld,
    output logic [ADDR_W-1:0] first_err_addr
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic              s_vld;
    logic [ADDR_W-1:0] s_addr;

    ram_rd_dly #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_dly (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .in_vld   (tap.ram_en_b),
        .in_addr  (tap.ram_addr_b),
        .out_vld  (s_vld),
        .out_addr (s_addr)
    );

    chk_state_e        state_q, state_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic              pass_err_q, pass_err_d;
    logic [DATA_W-1:0] exp_dat;
    logic              mis;
    logic              do_cmp, do_seq, do_done, data_err;
    logic [ERR_W:0]    err_sum;
    logic [ERR_W-1:0]  err_nxt;

    assign exp_dat  = DATA_W'(exp_word(32'(s_addr), DATA_OFS));
    assign mis      = (tap.ram_rd_data != exp_dat);
    assign data_err = do_cmp & mis;

    always_comb begin
        state_d    = state_q;
        exp_addr_d = exp_addr_q;
        pass_err_d = pass_err_q;
        do_cmp     = 1'b0;
        do_seq     = 1'b0;
        do_done    = 1'b0;
        if (s_vld) begin
            case (state_q)
                IDLE: begin
                    // Only address 0 opens a pass; anything else is stray traffic.
                    if (s_addr == '0) begin
                        do_cmp     = 1'b1;
                        exp_addr_d = ADDR_W'(1);
                        pass_err_d = mis;
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    if (s_addr == exp_addr_q) begin
                        do_cmp     = 1'b1;
                        exp_addr_d = exp_addr_q + 1'b1;   // wraps to 0 after the last address
                        pass_err_d = pass_err_q | mis;
                        if (s_addr == LAST_ADDR) begin
                            do_done = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        do_seq = 1'b1;
                        if (s_addr == '0) begin
                            // Aborted pass, but this sample legitimately opens the next one.
                            do_cmp     = 1'b1;
                            exp_addr_d = ADDR_W'(1);
                            pass_err_d = mis;
                        end else begin
                            exp_addr_d = '0;
                            state_d    = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Saturating add of up to two error events; the extra top bit flags overflow.
    assign err_sum = {1'b0, err_cnt} + (ERR_W+1)'({1'b0, do_seq} + {1'b0, data_err});
    assign err_nxt = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            exp_addr_q <= '0;
            pass_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_addr_q <= exp_addr_d;
            pass_err_q <= pass_err_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            chk_vld        <= 1'b0;
            chk_err        <= 1'b0;
            seq_err        <= 1'b0;
            pass_done      <= 1'b0;
            pass_ok        <= 1'b0;
            err_cnt        <= '0;
            pass_cnt       <= '0;
            first_err_vld  <= 1'b0;
            first_err_addr <= '0;
        end else begin
            chk_vld   <= do_cmp;
            chk_err   <= data_err;
            seq_err   <= do_seq;
            pass_done <= do_done;
            err_cnt   <= err_nxt;
            if (do_done) begin
                pass_ok  <= ~pass_err_d;
                pass_cnt <= pass_cnt + 1'b1;
            end
            if (data_err && !first_err_vld) begin
                first_err_vld  <= 1'b1;
                first_err_addr <= s_addr;
            end
        end
    end
endmodule

// File: tb/tb_ram_rd_chk.sv
// Bench for ram_rd_chk: two instances (RD_LAT=1/ERR_W=16 and RD_LAT=2/ERR_W=8) share one
// read-address stream; a behavioural RAM per instance returns address data with optional
// corruption at the matching latency.
module tb_ram_rd_chk;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic       en_drv   = 1'b0;
    logic [5:0] addr_drv = '0;
    int         bad_mode = 0;     // 0 clean, 1 one address corrupted, 2 every word corrupted
    int         bad_addr = 0;

    logic [5:0] addr_pipe [2];
    logic [7:0] rd_a, rd_b;

    always @(posedge sys_clk) begin
        addr_pipe[0] <= addr_drv;
        addr_pipe[1] <= addr_pipe[0];
    end

    always @* begin
        rd_a = (bad_mode == 2 || (bad_mode == 1 && int'(addr_pipe[0]) == bad_addr)) ? 8'hFF : {2'b00, addr_pipe[0]};
        rd_b = (bad_mode == 2 || (bad_mode == 1 && int'(addr_pipe[1]) == bad_addr)) ? 8'hFF : {2'b00, addr_pipe[1]};
    end

    ram_rd_chk_if #(.ADDR_W(6), .DATA_W(8)) ifa ();
    ram_rd_chk_if #(.ADDR_W(6), .DATA_W(8)) ifb ();
    assign ifa.ram_en_b    = en_drv;
    assign ifa.ram_addr_b  = addr_drv;
    assign ifa.ram_rd_data = rd_a;
    assign ifb.ram_en_b    = en_drv;
    assign ifb.ram_addr_b  = addr_drv;
    assign ifb.ram_rd_data = rd_b;

    logic        chk_vld_a, chk_err_a, seq_err_a, pass_done_a, pass_ok_a, fev_a;
    logic [15:0] err_cnt_a, pass_cnt_a;
    logic [5:0]  fea_a;
    logic        chk_vld_b, chk_err_b, seq_err_b, pass_done_b, pass_ok_b, fev_b;
    logic [7:0]  err_cnt_b;
    logic [15:0] pass_cnt_b;
    logic [5:0]  fea_b;

    ram_rd_chk #(.ADDR_W(6), .DATA_W(8), .RD_LAT(1), .DATA_OFS(0), .ERR_W(16)) u_dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tap(ifa),
        .chk_vld(chk_vld_a), .chk_err(chk_err_a), .seq_err(seq_err_a), .pass_done(pass_done_a),
        .pass_ok(pass_ok_a), .err_cnt(err_cnt_a), .pass_cnt(pass_cnt_a),
        .first_err_vld(fev_a), .first_err_addr(fea_a)
    );

    ram_rd_chk #(.ADDR_W(6), .DATA_W(8), .RD_LAT(2), .DATA_OFS(0), .ERR_W(8)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tap(ifb),
        .chk_vld(chk_vld_b), .chk_err(chk_err_b), .seq_err(seq_err_b), .pass_done(pass_done_b),
        .pass_ok(pass_ok_b), .err_cnt(err_cnt_b), .pass_cnt(pass_cnt_b),
        .first_err_vld(fev_b), .first_err_addr(fea_b)
    );

    int tests  = 0;
    int failed = 0;
    int nvld [2];
    int nerr [2];
    int nseq [2];
    int ndone[2];

    typedef struct {
        int lo, hi, gap, bad, bad_at;
        int n_vld, n_err, n_seq, n_done;
        int ok, ecnt, pcnt, fev, fea;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 2; i++) begin
            nvld[i] = 0; nerr[i] = 0; nseq[i] = 0; ndone[i] = 0;
        end
    endtask

    // One cycle: sample the pulses away from the active edge, then drive the next inputs.
    task automatic tick(input logic en, input logic [5:0] addr);
        @(negedge sys_clk);
        if (chk_vld_a)   nvld[0]++;
        if (chk_err_a)   nerr[0]++;
        if (seq_err_a)   nseq[0]++;
        if (pass_done_a) ndone[0]++;
        if (chk_vld_b)   nvld[1]++;
        if (chk_err_b)   nerr[1]++;
        if (seq_err_b)   nseq[1]++;
        if (pass_done_b) ndone[1]++;
        en_drv   = en;
        addr_drv = addr;
    endtask

    task automatic drain();
        for (int k = 0; k < 6; k++) tick(1'b0, addr_drv);
    endtask

    task automatic run_reads(input int lo, input int hi, input int gap);
        for (int a = lo; a <= hi; a++) begin
            tick(1'b1, 6'(a));
            if (gap != 0) tick(1'b0, 6'(a));
        end
        drain();
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, ".a.chk_vld"},   int'(chk_vld_a),   0);
        check({pfx, ".a.chk_err"},   int'(chk_err_a),   0);
        check({pfx, ".a.seq_err"},   int'(seq_err_a),   0);
        check({pfx, ".a.pass_done"}, int'(pass_done_a), 0);
        check({pfx, ".a.pass_ok"},   int'(pass_ok_a),   0);
        check({pfx, ".a.err_cnt"},   int'(err_cnt_a),   0);
        check({pfx, ".a.pass_cnt"},  int'(pass_cnt_a),  0);
        check({pfx, ".a.fev"},       int'(fev_a),       0);
        check({pfx, ".a.fea"},       int'(fea_a),       0);
        check({pfx, ".b.chk_vld"},   int'(chk_vld_b),   0);
        check({pfx, ".b.chk_err"},   int'(chk_err_b),   0);
        check({pfx, ".b.seq_err"},   int'(seq_err_b),   0);
        check({pfx, ".b.pass_done"}, int'(pass_done_b), 0);
        check({pfx, ".b.pass_ok"},   int'(pass_ok_b),   0);
        check({pfx, ".b.err_cnt"},   int'(err_cnt_b),   0);
        check({pfx, ".b.pass_cnt"},  int'(pass_cnt_b),  0);
        check({pfx, ".b.fev"},       int'(fev_b),       0);
        check({pfx, ".b.fea"},       int'(fea_b),       0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first_a, first_b;
        //        lo hi gap bad at  vld err seq done ok ecnt pcnt fev fea
        vecs[0]  = '{0, 63, 0, 0, 0,  64,  0, 0, 1,  1,   0,  1, 0,  0};
        vecs[1]  = '{0, 63, 0, 1, 17, 64,  1, 0, 1,  0,   1,  2, 1, 17};
        vecs[2]  = '{0, 63, 0, 0, 0,  64,  0, 0, 1,  1,   1,  3, 1, 17};
        vecs[3]  = '{0,  9, 0, 0, 0,  10,  0, 0, 0,  1,   1,  3, 1, 17};
        vecs[4]  = '{12, 12, 0, 0, 0,  0,  0, 1, 0,  1,   2,  3, 1, 17};
        vecs[5]  = '{0, 63, 0, 0, 0,  64,  0, 0, 1,  1,   2,  4, 1, 17};
        vecs[6]  = '{0, 63, 1, 0, 0,  64,  0, 0, 1,  1,   2,  5, 1, 17};
        vecs[7]  = '{0, 20, 0, 0, 0,  21,  0, 0, 0,  1,   2,  5, 1, 17};
        vecs[8]  = '{0, 63, 0, 0, 0,  64,  0, 1, 1,  1,   3,  6, 1, 17};
        vecs[9]  = '{0, 63, 0, 1, 40, 64,  1, 0, 1,  0,   4,  7, 1, 17};
        vecs[10] = '{5,  9, 0, 0, 0,   0,  0, 0, 0,  0,   4,  7, 1, 17};
        vecs[11] = '{0, 63, 0, 2, 0,  64, 64, 0, 1,  0,  68,  8, 1, 17};
        vecs[12] = '{0, 63, 0, 2, 0,  64, 64, 0, 1,  0, 132,  9, 1, 17};
        vecs[13] = '{0, 63, 0, 2, 0,  64, 64, 0, 1,  0, 196, 10, 1, 17};
        vecs[14] = '{0, 63, 0, 2, 0,  64, 64, 0, 1,  0, 260, 11, 1, 17};
        vecs[15] = '{0, 63, 0, 2, 0,  64, 64, 0, 1,  0, 324, 12, 1, 17};
        vecs[16] = '{0, 63, 0, 0, 0,  64,  0, 0, 1,  1, 324, 13, 1, 17};

        clr_cnt();
        sys_rst = 1'b1;
        for (int k = 0; k < 3; k++) tick(1'b0, 6'd0);
        check_zero("reset");
        sys_rst = 1'b0;
        drain();

        for (int r = 0; r < 17; r++) begin
            string p;
            int ecnt_b;
            p        = $sformatf("row%0d", r);
            ecnt_b   = (vecs[r].ecnt > 255) ? 255 : vecs[r].ecnt;
            bad_mode = vecs[r].bad;
            bad_addr = vecs[r].bad_at;
            clr_cnt();
            run_reads(vecs[r].lo, vecs[r].hi, vecs[r].gap);
            check({p, ".a.n_vld"},    nvld[0],          vecs[r].n_vld);
            check({p, ".a.n_err"},    nerr[0],          vecs[r].n_err);
            check({p, ".a.n_seq"},    nseq[0],          vecs[r].n_seq);
            check({p, ".a.n_done"},   ndone[0],         vecs[r].n_done);
            check({p, ".a.pass_ok"},  int'(pass_ok_a),  vecs[r].ok);
            check({p, ".a.err_cnt"},  int'(err_cnt_a),  vecs[r].ecnt);
            check({p, ".a.pass_cnt"}, int'(pass_cnt_a), vecs[r].pcnt);
            check({p, ".a.fev"},      int'(fev_a),      vecs[r].fev);
            check({p, ".a.fea"},      int'(fea_a),      vecs[r].fea);
            check({p, ".b.n_vld"},    nvld[1],          vecs[r].n_vld);
            check({p, ".b.n_err"},    nerr[1],          vecs[r].n_err);
            check({p, ".b.n_seq"},    nseq[1],          vecs[r].n_seq);
            check({p, ".b.n_done"},   ndone[1],         vecs[r].n_done);
            check({p, ".b.pass_ok"},  int'(pass_ok_b),  vecs[r].ok);
            check({p, ".b.err_cnt"},  int'(err_cnt_b),  ecnt_b);
            check({p, ".b.pass_cnt"}, int'(pass_cnt_b), vecs[r].pcnt);
            check({p, ".b.fev"},      int'(fev_b),      vecs[r].fev);
            check({p, ".b.fea"},      int'(fea_b),      vecs[r].fea);
        end
        bad_mode = 0;

        // Reset in the middle of a pass, asserted on the cycle address 30 is enabled.
        for (int a = 0; a < 30; a++) tick(1'b1, 6'(a));
        tick(1'b1, 6'd30);
        sys_rst = 1'b1;
        tick(1'b1, 6'd31);
        sys_rst = 1'b0;
        check_zero("midrst");
        clr_cnt();
        for (int a = 32; a < 64; a++) tick(1'b1, 6'(a));
        drain();
        check("midrst.a.ignored_vld", nvld[0], 0);
        check("midrst.a.ignored_seq", nseq[0], 0);
        check("midrst.b.ignored_vld", nvld[1], 0);
        check("midrst.b.ignored_seq", nseq[1], 0);
        clr_cnt();
        run_reads(0, 63, 0);
        check("postrst.a.n_vld",    nvld[0],          64);
        check("postrst.a.n_done",   ndone[0],         1);
        check("postrst.a.pass_cnt", int'(pass_cnt_a), 1);
        check("postrst.a.pass_ok",  int'(pass_ok_a),  1);
        check("postrst.a.err_cnt",  int'(err_cnt_a),  0);
        check("postrst.a.fev",      int'(fev_a),      0);
        check("postrst.b.n_vld",    nvld[1],          64);
        check("postrst.b.n_done",   ndone[1],         1);
        check("postrst.b.pass_cnt", int'(pass_cnt_b), 1);
        check("postrst.b.pass_ok",  int'(pass_ok_b),  1);
        check("postrst.b.err_cnt",  int'(err_cnt_b),  0);
        check("postrst.b.fev",      int'(fev_b),      0);

        // Latency: single enable at address 0; chk_vld must appear RD_LAT+1 cycles later.
        clr_cnt();
        first_a = 0;
        first_b = 0;
        tick(1'b1, 6'd0);
        for (int k = 1; k <= 6; k++) begin
            tick(1'b0, 6'd0);
            if (chk_vld_a && first_a == 0) first_a = k;
            if (chk_vld_b && first_b == 0) first_b = k;
        end
        check("lat.a.cycle", first_a, 2);
        check("lat.b.cycle", first_b, 3);
        check("lat.a.n_vld", nvld[0], 1);
        check("lat.b.n_vld", nvld[1], 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
